// File: rtl/mult_div.sv
`default_nettype none
// ============================================================================
// Module      : mult_div
// Description : Iterative 32x32 multiply / divide unit. One radix-2 step per
//               clock: shift-add multiply into a 64-bit accumulator, restoring
//               divide with a 33-bit partial remainder. Signed operations run
//               on operand magnitudes and are sign-corrected at the end.
// Ports       : clk      - clock, all state on its rising edge
//               reset_n  - synchronous active-low reset
//               start    - operation request, sampled only while idle
//               op       - 00 mult, 01 multu, 10 div, 11 divu
//               a, b     - multiplicand/dividend, multiplier/divisor
//               busy     - operation in progress
//               done     - one-cycle pulse, hi/lo valid
//               hi, lo   - product {hi,lo}, or remainder (hi) / quotient (lo)
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [4:0] C_LAST_ITER = 5'd31;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;      // negate product / quotient
    logic        r_neg_rem;      // negate remainder (dividend was negative)
    logic        r_div_zero;
    logic [31:0] r_dividend;     // raw dividend, returned on divide by zero
    logic [31:0] r_opa;          // multiplicand magnitude
    logic [31:0] r_opb;          // divisor magnitude
    logic [63:0] r_acc;          // multiply: {partial product, multiplier}
    logic [32:0] r_rem;          // divide: partial remainder
    logic [31:0] r_quo;          // divide: dividend shifting out, quotient in

    // Operand magnitudes; unsigned ops (op[0]=1) pass operands through.
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[31];
    assign w_b_neg  = w_signed & b[31];
    assign w_mag_a  = w_a_neg ? (~a + 32'd1) : a;
    assign w_mag_b  = w_b_neg ? (~b + 32'd1) : b;

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (acc[0]) is set, then shift the whole thing right.
    // The 33-bit sum keeps the carry, which becomes the new acc[63].
    logic [32:0] w_add;
    logic [63:0] w_acc_next;

    assign w_add      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opa} : 33'd0);
    assign w_acc_next = {w_add, r_acc[31:1]};

    // Restoring step: shift the next dividend bit into the remainder and try
    // to subtract the divisor; a non-negative result yields quotient bit 1.
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_fits;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {2'b00, r_opb};
    assign w_fits  = ~w_diff[33];

    // Sign correction applied in FINISH.
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_quo + 32'd1) : r_quo;
    assign w_rem  = r_neg_rem ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_dividend <= 32'd0;
            r_opa      <= 32'd0;
            r_opb      <= 32'd0;
            r_acc      <= 64'd0;
            r_rem      <= 33'd0;
            r_quo      <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_is_div   <= op[1];
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= (b == 32'd0);
                        r_dividend <= a;
                        r_opa      <= w_mag_a;
                        r_opb      <= w_mag_b;
                        r_acc      <= {32'd0, w_mag_b};
                        r_rem      <= 33'd0;
                        r_quo      <= w_mag_a;
                        r_cnt      <= 5'd0;
                        busy       <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (r_is_div) begin
                        r_rem <= w_fits ? w_diff[32:0] : w_shift[32:0];
                        r_quo <= {r_quo[30:0], w_fits};
                    end else begin
                        r_acc <= w_acc_next;
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == C_LAST_ITER) begin
                        r_state <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    if (r_is_div) begin
                        // Divide by zero bypasses sign correction entirely.
                        if (r_div_zero) begin
                            hi <= r_dividend;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= w_rem;
                            lo <= w_quo;
                        end
                    end else begin
                        hi <= w_prod[63:32];
                        lo <= w_prod[31:0];
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, listed first among its ports.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL be the operation request, sampled only in IDLE.
REQ-005 op  input  2  SHALL select the operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 a  input  32  SHALL be the multiplicand or dividend, captured when start is accepted.
REQ-007 b  input  32  SHALL be the multiplier or divisor, captured when start is accepted.
REQ-008 busy  output  1  SHALL be high while an operation is in progress.
REQ-009 done  output  1  SHALL pulse high for one cycle when hi and lo become valid.
REQ-010 hi  output  32  SHALL hold the upper product word or the remainder.
REQ-011 lo  output  32  SHALL hold the lower product word or the quotient.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, FINISH.
REQ-013 IDLE->RUN SHALL occur on the edge where start=1; a, b and op are registered on that edge (E0).
REQ-014 Inputs a, b, op and start SHALL be ignored outside IDLE, with no effect on the result.
REQ-015 Signed ops SHALL run on operand magnitudes; unsigned ops SHALL run on raw operands.
REQ-016 Multiply SHALL be radix-2 shift-add with a 64-bit accumulator, one multiplier bit per cycle.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-018 RUN SHALL last exactly 32 cycles, counted by a 5-bit iteration counter; RUN->FINISH follows the 32nd iteration.
REQ-019 FINISH SHALL apply sign correction, load hi/lo and assert done for one cycle, then return to IDLE.
REQ-020 Latency: done SHALL be high in the 34th cycle after E0, with hi/lo valid in the same cycle.
REQ-021 busy SHALL be high from the cycle after E0 through the cycle before done, and low while done is high.
REQ-022 Back-to-back: start SHALL be accepted on the edge that ends the done cycle.
REQ-023 mult/multu SHALL produce {hi,lo} = the full 64-bit product, two's-complement for mult.
REQ-024 Product sign SHALL be negated when the operand signs differ.
REQ-025 div/divu SHALL produce lo = quotient truncated toward zero and hi = remainder.
REQ-026 The sign of hi after div SHALL equal the sign of the dividend.
REQ-027 Divide by zero SHALL give hi = dividend and lo = 0xFFFFFFFF, at normal latency.
REQ-028 div of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-029 hi and lo SHALL hold their values between operations and change only in FINISH.

Reset
REQ-030 While reset_n=0 at a clock edge, the state SHALL become IDLE and busy, done, hi, lo and the counter SHALL become 0.
REQ-031 Reset during RUN or FINISH SHALL abort the operation: no done pulse, and hi/lo SHALL be 0.
REQ-032 reset_n=0 SHALL take priority over start on the same edge.

Verification
REQ-033 The bench SHALL check: mult, a=125, b=-360 -> hi=0xFFFFFFFF, lo=0xFFFF5038, done exactly 34 cycles after E0.
REQ-034 The bench SHALL check: multu, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 The bench SHALL check: div, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu, a=100, b=0 -> hi=100, lo=0xFFFFFFFF.
REQ-036 The bench SHALL check: div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 The bench SHALL check: start with op=div at cycle 5 after a multiply starts -> ignored, and the product matches the multiply alone.
REQ-038 The bench SHALL check: reset_n=0 at cycle 10 of RUN -> busy=0, hi=lo=0, no done; a new start then completes normally.
